// File: rtl/panel_trabajos.sv
// panel_trabajos: front-panel job queue and print/scan command sequencer toward the engine.
// Build option: `define AUTO_RETRY_EN re-issues a job once after its first completion timeout.
module panel_trabajos #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       prendido,
    input  logic       btn_imprimir,
    input  logic       btn_escanear,
    input  logic       sel_color,
    input  logic [0:1] sel_paginas,
    input  logic [0:1] sel_ajustes,
    input  logic       limpiar,
    output logic       imprimir,
    output logic       escanear,
    output logic       color,
    output logic [0:1] paginas,
    output logic [0:1] ajustes_escaner,
    input  logic       esc_escaner,
    input  logic       fin_color,
    input  logic       fin_negro,
    output logic [0:6] display1,
    output logic [0:6] display2
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_BLOQ, S_ERROR} state_t;

    state_t          state;
    logic            btn_imp_q, btn_esc_q, esc_q;
    logic            rise_imp, rise_esc;
    logic            push_r, push_ok, issue_go, blk;
    logic [5:0]      job_r, head;
    logic [5:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic            ovf;
    logic [CW-1:0]   cnt;
    logic            act_print;
`ifdef AUTO_RETRY_EN
    logic            retried;
`endif

    always_comb begin
        rise_imp = btn_imprimir & ~btn_imp_q;
        rise_esc = btn_escanear & ~btn_esc_q;
        head     = mem[rd_ptr];
        // job word {print, color, paginas, ajustes}; only print jobs consume ink
        blk      = head[5] && (head[4] ? fin_color : fin_negro);
        issue_go = prendido && !blk &&
                   ((state == S_IDLE && count != '0) || state == S_BLOQ);
        push_ok  = push_r && (count != (AW+1)'(DEPTH) || issue_go);
    end

    // Edge capture: a press registers here and is pushed on the following edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_imp_q <= btn_imprimir;
            btn_esc_q <= btn_escanear;
            push_r    <= 1'b0;
            job_r     <= '0;
        end else begin
            btn_imp_q <= btn_imprimir;
            btn_esc_q <= btn_escanear;
            push_r    <= prendido && (rise_imp || rise_esc);
            job_r     <= {rise_imp, sel_color, sel_paginas, sel_ajustes};
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= job_r;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (issue_go)
                rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !issue_go)
                count <= count + (AW+1)'(1);
            else if (!push_ok && issue_go)
                count <= count - (AW+1)'(1);
            if (issue_go)
                ovf <= 1'b0;
            else if (push_r && !push_ok)
                ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            imprimir        <= 1'b0;
            escanear        <= 1'b0;
            color           <= 1'b0;
            paginas         <= '0;
            ajustes_escaner <= '0;
            cnt             <= '0;
            act_print       <= 1'b0;
            esc_q           <= esc_escaner;
`ifdef AUTO_RETRY_EN
            retried         <= 1'b0;
`endif
        end else begin
            esc_q    <= esc_escaner;
            imprimir <= 1'b0;
            escanear <= 1'b0;
            if (!prendido) begin
                state <= S_IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    // BLOQ re-evaluates the same head entry that blocked in IDLE
                    S_IDLE, S_BLOQ: begin
                        if (issue_go) begin
                            state           <= S_ISSUE;
                            imprimir        <= head[5];
                            escanear        <= ~head[5];
                            act_print       <= head[5];
                            color           <= head[4];
                            paginas         <= head[3:2];
                            ajustes_escaner <= head[1:0];
`ifdef AUTO_RETRY_EN
                            retried         <= 1'b0;
`endif
                        end else if (count != '0) begin
                            state <= S_BLOQ;
                        end
                    end
                    S_ISSUE: begin
                        state <= S_WAIT;
                        cnt   <= '0;
                    end
                    S_WAIT: begin
                        if (esc_q && !esc_escaner) begin
                            state <= S_IDLE;
                        end else if (cnt == CW'(TIMEOUT - 1)) begin
                            cnt <= '0;
`ifdef AUTO_RETRY_EN
                            if (!retried) begin
                                retried  <= 1'b1;
                                state    <= S_ISSUE;
                                imprimir <= act_print;
                                escanear <= ~act_print;
                            end else begin
                                state <= S_ERROR;
                            end
`else
                            state <= S_ERROR;
`endif
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    S_ERROR: begin
                        cnt <= cnt + CW'(1);
                        if (limpiar) begin
                            state <= S_IDLE;
                            cnt   <= '0;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // Segment order a..g, a is index 0.
    always_comb begin
        case (4'(count))
            4'd0:    display1 = 7'b1111110;
            4'd1:    display1 = 7'b0110000;
            4'd2:    display1 = 7'b1101101;
            4'd3:    display1 = 7'b1111001;
            4'd4:    display1 = 7'b0110011;
            4'd5:    display1 = 7'b1011011;
            4'd6:    display1 = 7'b1011111;
            4'd7:    display1 = 7'b1110000;
            4'd8:    display1 = 7'b1111111;
            default: display1 = 7'b0000000;
        endcase

        display2 = 7'b0000110;
        if (ovf) begin
            display2 = 7'b1000111;
        end else begin
            case (state)
                S_IDLE:           display2 = 7'b0000110;
                S_ISSUE, S_WAIT:  display2 = act_print ? 7'b1100111 : 7'b1001111;
                S_BLOQ:           display2 = 7'b0011111;
                S_ERROR:          display2 = cnt[CW-1] ? 7'b0000000 : 7'b1001111;
                default:          display2 = 7'b0000110;
            endcase
        end
    end
endmodule
